// File: rtl/uart_report_pkg.sv
// Shared constants and types for the counter reporter: ASCII bytes of the
// report line, byte-FSM states and the message length helper.
package uart_report_pkg;

    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_C     = 8'h43;
    localparam logic [7:0] ASCII_COLON = 8'h3A;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        PRESENT,
        GAP
    } state_e;

    // "Ck: " header, DIGITS digits, CR, LF.
    function automatic int msg_len(input int digits);
        return digits + 6;
    endfunction

endpackage

// File: rtl/uart_counter_reporter_if.sv
// Byte handshake towards uart_tx: din is valid while empty is low, and a
// rising edge on re means the byte has been consumed.
interface uart_counter_reporter_if;
    logic [7:0] din;
    logic       empty;
    logic       re;

    modport master (output din, output empty, input re);
    modport slave  (input din, input empty, output re);
endinterface

// File: rtl/bin2dec_seq.sv
// Sequential double-dabble: one input bit per cycle, so CNT_W cycles after
// start the BCD result is valid and done stays high until the next start.
module bin2dec_seq #(
    parameter int CNT_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [CNT_W-1:0]      bin,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);
    localparam int STEP_W = $clog2(CNT_W + 1);

    logic [CNT_W-1:0]    r_bin;
    logic [4*DIGITS-1:0] r_bcd;
    logic [4*DIGITS-1:0] w_adj;
    logic [STEP_W-1:0]   r_step;
    logic                r_run;
    logic                r_done;

    // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        w_adj = r_bcd;
        for (int d = 0; d < DIGITS; d++) begin
            if (r_bcd[4*d +: 4] >= 4'd5) begin
                w_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bin  <= '0;
            r_bcd  <= '0;
            r_step <= '0;
            r_run  <= 1'b0;
            r_done <= 1'b0;
        end else if (start) begin
            r_bin  <= bin;
            r_bcd  <= '0;
            r_step <= '0;
            r_run  <= 1'b1;
            r_done <= 1'b0;
        end else if (r_run) begin
            r_bcd  <= {w_adj[4*DIGITS-2:0], r_bin[CNT_W-1]};
            r_bin  <= r_bin << 1;
            r_step <= r_step + STEP_W'(1);
            if (r_step == STEP_W'(CNT_W - 1)) begin
                r_run  <= 1'b0;
                r_done <= 1'b1;
            end
        end
    end

    assign done = r_done;
    assign bcd  = r_bcd;
endmodule

// File: rtl/uart_counter_reporter.sv
// Bank of up/down counters; every real value change is reported as an ASCII
// line "Ck: ddd\r\n" over the uart_tx byte handshake, channels served round-robin.
module uart_counter_reporter
    import uart_report_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 8,
    parameter int DIGITS = 3,
    parameter int WRAP   = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CH-1:0]         inc,
    input  logic [NUM_CH-1:0]         dec,
    output logic [NUM_CH*CNT_W-1:0]   cnt,
    output logic                      busy,
    uart_counter_reporter_if.master   tx
);
    localparam int MSG_LEN = msg_len(DIGITS);
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int IDX_W   = $clog2(MSG_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0]    r_cnt [NUM_CH];
    logic [NUM_CH-1:0]   r_pend, w_up, w_dn, w_chg, w_clr;
    state_e              r_state;
    logic [CH_W-1:0]     r_ch, r_last, w_sel;
    logic [IDX_W-1:0]    r_idx, w_next_idx;
    logic [7:0]          r_din;
    logic                r_empty, r_re_d;
    logic                w_re_rise, w_start, w_conv_done, w_next_ready;
    logic [4*DIGITS-1:0] w_bcd;

    function automatic logic [7:0] msg_byte(input logic [IDX_W-1:0] idx,
                                            input logic [CH_W-1:0]  ch,
                                            input logic [4*DIGITS-1:0] bcd);
        int i;
        i = int'(idx);
        if (i == 0)                return ASCII_C;
        else if (i == 1)           return ASCII_ZERO + 8'(ch);
        else if (i == 2)           return ASCII_COLON;
        else if (i == 3)           return ASCII_SPACE;
        else if (i < 4 + DIGITS)   return ASCII_ZERO + {4'h0, bcd[4*(DIGITS+3-i) +: 4]};
        else if (i == 4 + DIGITS)  return ASCII_CR;
        else                       return ASCII_LF;
    endfunction

    // A saturating no-op is not a change, so it must not raise pend.
    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            w_up[k]  = inc[k] & ~dec[k];
            w_dn[k]  = dec[k] & ~inc[k];
            w_chg[k] = (w_up[k] && (WRAP != 0 || r_cnt[k] != CNT_MAX)) ||
                       (w_dn[k] && (WRAP != 0 || r_cnt[k] != '0));
        end
    end

    always_comb begin : arbiter
        logic            hit;
        logic [CH_W-1:0] j;
        hit   = 1'b0;
        j     = '0;
        w_sel = r_last;
        for (int i = 1; i <= NUM_CH; i++) begin
            j = CH_W'((int'(r_last) + i) % NUM_CH);
            if (!hit && r_pend[j]) begin
                hit   = 1'b1;
                w_sel = j;
            end
        end
    end

    assign w_clr        = (r_state == LOAD) ? (NUM_CH'(1) << w_sel) : '0;
    assign w_start      = (r_state == LOAD);
    assign w_re_rise    = tx.re & ~r_re_d;
    assign w_next_idx   = r_idx + IDX_W'(1);
    assign w_next_ready = (int'(r_idx) + 1 < 4) || w_conv_done;

    // NOTE: the counter array sits in flops, not RAM, so it is cleared by reset like any register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '{default: '0};
            r_pend <= '0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (w_chg[k]) r_cnt[k] <= w_up[k] ? r_cnt[k] + CNT_W'(1) : r_cnt[k] - CNT_W'(1);
            end
            r_pend <= (r_pend & ~w_clr) | w_chg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_ch    <= '0;
            r_last  <= CH_W'(NUM_CH - 1);
            r_idx   <= '0;
            r_din   <= 8'h00;
            r_empty <= 1'b1;
            r_re_d  <= 1'b0;
        end else begin
            r_re_d <= tx.re;
            case (r_state)
                IDLE: if (|r_pend) r_state <= LOAD;
                LOAD: begin
                    r_ch    <= w_sel;
                    r_last  <= w_sel;
                    r_idx   <= '0;
                    r_din   <= ASCII_C;
                    r_empty <= 1'b0;
                    r_state <= PRESENT;
                end
                PRESENT: if (w_re_rise) begin
                    r_empty <= 1'b1;
                    r_state <= GAP;
                end
                GAP: begin
                    if (r_idx == IDX_W'(MSG_LEN - 1)) begin
                        r_state <= (|r_pend) ? LOAD : IDLE;
                    end else if (w_next_ready) begin
                        r_idx   <= w_next_idx;
                        r_din   <= msg_byte(w_next_idx, r_ch, w_bcd);
                        r_empty <= 1'b0;
                        r_state <= PRESENT;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    bin2dec_seq #(.CNT_W(CNT_W), .DIGITS(DIGITS)) u_bin2dec (
        .clk   (clk),
        .rst   (rst),
        .start (w_start),
        .bin   (r_cnt[w_sel]),
        .done  (w_conv_done),
        .bcd   (w_bcd)
    );

    for (genvar k = 0; k < NUM_CH; k++) begin : g_cnt_out
        assign cnt[k*CNT_W +: CNT_W] = r_cnt[k];
    end

    assign busy     = (r_state != IDLE);
    assign tx.din   = r_din;
    assign tx.empty = r_empty;
endmodule

// File: tb/tb_uart_counter_reporter.sv
// Directed bench: dut_a (4 ch, wrap) and dut_b (2 ch, saturate) driven by an
// ideal uart_tx model; report lines compared against hand-written strings.
module tb_uart_counter_reporter;
    logic        clk = 1'b0;
    logic        rst_a, rst_b;
    logic [3:0]  inc_a, dec_a;
    logic [1:0]  inc_b, dec_b;
    logic [31:0] cnt_a;
    logic [15:0] cnt_b;
    logic        busy_a, busy_b;
    int          n_checks = 0;
    int          n_pass   = 0;

    always #5 clk = ~clk;

    uart_counter_reporter_if if_a ();
    uart_counter_reporter_if if_b ();

    uart_counter_reporter #(.NUM_CH(4), .CNT_W(8), .DIGITS(3), .WRAP(1)) dut_a (
        .clk(clk), .rst(rst_a), .inc(inc_a), .dec(dec_a),
        .cnt(cnt_a), .busy(busy_a), .tx(if_a)
    );

    uart_counter_reporter #(.NUM_CH(2), .CNT_W(8), .DIGITS(3), .WRAP(0)) dut_b (
        .clk(clk), .rst(rst_b), .inc(inc_b), .dec(dec_b),
        .cnt(cnt_b), .busy(busy_b), .tx(if_b)
    );

    task automatic do_reset(input bit sel);
        @(negedge clk);
        if (sel) rst_b = 1'b1; else rst_a = 1'b1;
        repeat (2) @(negedge clk);
        rst_a = 1'b0;
        rst_b = 1'b0;
    endtask

    task automatic recv_byte(input bit sel, input int tmo, output logic [7:0] b, output bit ok);
        ok = 1'b0;
        b  = 8'h00;
        for (int i = 0; i < tmo; i++) begin
            @(negedge clk);
            if ((sel ? if_b.empty : if_a.empty) == 1'b0) begin
                b = sel ? if_b.din : if_a.din;
                if (sel) if_b.re = 1'b1; else if_a.re = 1'b1;
                @(negedge clk);
                if_a.re = 1'b0;
                if_b.re = 1'b0;
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic recv_line(input bit sel, output logic [71:0] line, output bit ok);
        logic [7:0] b;
        line = '0;
        for (int i = 0; i < 9; i++) begin
            recv_byte(sel, 200, b, ok);
            if (!ok) return;
            line = {line[63:0], b};
        end
    endtask

    task automatic watch_quiet(input bit sel, input int n, output bit active);
        active = 1'b0;
        repeat (n) begin
            @(negedge clk);
            if (sel ? (!if_b.empty || busy_b) : (!if_a.empty || busy_a)) active = 1'b1;
        end
    endtask

    task automatic test_reset();
        inc_a = '0; dec_a = '0; inc_b = '0; dec_b = '0;
        if_a.re = 1'b0; if_b.re = 1'b0;
        rst_a = 1'b1; rst_b = 1'b1;
        repeat (3) @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0;
        @(negedge clk);
        n_checks++; if (cnt_a !== 32'h0) $display("FAIL reset_cnt_a got %h exp 0", cnt_a); else n_pass++;
        n_checks++; if (if_a.empty !== 1'b1) $display("FAIL reset_empty_a got %b exp 1", if_a.empty); else n_pass++;
        n_checks++; if (if_a.din !== 8'h00) $display("FAIL reset_din_a got %h exp 00", if_a.din); else n_pass++;
        n_checks++; if (busy_a !== 1'b0) $display("FAIL reset_busy_a got %b exp 0", busy_a); else n_pass++;
        n_checks++; if (cnt_b !== 16'h0) $display("FAIL reset_cnt_b got %h exp 0", cnt_b); else n_pass++;
        n_checks++; if (if_b.empty !== 1'b1) $display("FAIL reset_empty_b got %b exp 1", if_b.empty); else n_pass++;
    endtask

    task automatic test_single_lines();
        logic [71:0] line, exp;
        bit ok;
        for (int v = 1; v <= 3; v++) begin
            @(negedge clk); inc_a = 4'b0001;
            @(negedge clk); inc_a = 4'b0000;
            if (v == 1) begin
                n_checks++; if (cnt_a[7:0] !== 8'd1) $display("FAIL cnt_latency got %0d exp 1", cnt_a[7:0]); else n_pass++;
                @(negedge clk);
                n_checks++; if ({busy_a, if_a.empty} !== 2'b11) $display("FAIL load_cycle busy/empty got %b exp 11", {busy_a, if_a.empty}); else n_pass++;
                @(negedge clk);
                n_checks++; if (if_a.empty !== 1'b0) $display("FAIL first_byte_latency empty got %b exp 0", if_a.empty); else n_pass++;
            end
            exp = {"C0: 00", 8'(8'h30 + v), 16'h0D0A};
            recv_line(1'b0, line, ok);
            n_checks++; if (!ok || line !== exp) $display("FAIL single_line_%0d got %h ok=%0d exp %h", v, line, ok, exp); else n_pass++;
        end
    endtask

    task automatic test_coalesce();
        logic [71:0] line, rest;
        logic [7:0] b;
        bit ok, ok2, act;
        @(negedge clk); inc_a = 4'b0001;
        @(negedge clk); inc_a = 4'b0000;
        recv_byte(1'b0, 200, b, ok);
        @(negedge clk); inc_a = 4'b0010;
        repeat (5) @(negedge clk);
        inc_a = 4'b0000;
        n_checks++; if (cnt_a[15:8] !== 8'd5) $display("FAIL coalesce_cnt1 got %0d exp 5", cnt_a[15:8]); else n_pass++;
        rest = '0;
        ok2 = ok;
        for (int i = 0; i < 8 && ok2; i++) begin
            recv_byte(1'b0, 200, b, ok2);
            rest = {rest[63:0], b};
        end
        line = {8'h43, rest[63:0]};
        n_checks++; if (!ok || !ok2 || line !== "C0: 004\r\n") $display("FAIL coalesce_ch0_line got %h exp %h", line, 72'("C0: 004\r\n")); else n_pass++;
        recv_line(1'b0, line, ok);
        n_checks++; if (!ok || line !== "C1: 005\r\n") $display("FAIL coalesce_ch1_line got %h ok=%0d exp %h", line, ok, 72'("C1: 005\r\n")); else n_pass++;
        repeat (2) @(negedge clk);
        watch_quiet(1'b0, 40, act);
        n_checks++; if (act !== 1'b0) $display("FAIL coalesce_no_extra got activity=%0d exp 0", act); else n_pass++;
    endtask

    task automatic test_wrap();
        logic [71:0] line;
        bit ok;
        do_reset(1'b0);
        @(negedge clk); dec_a = 4'b0001;
        @(negedge clk); dec_a = 4'b0000;
        n_checks++; if (cnt_a[7:0] !== 8'd255) $display("FAIL wrap_cnt got %0d exp 255", cnt_a[7:0]); else n_pass++;
        recv_line(1'b0, line, ok);
        n_checks++; if (!ok || line !== "C0: 255\r\n") $display("FAIL wrap_line got %h ok=%0d exp %h", line, ok, 72'("C0: 255\r\n")); else n_pass++;
    endtask

    task automatic test_saturate();
        logic [71:0] last;
        logic [7:0] b;
        bit ok, act;
        @(negedge clk); dec_b = 2'b01;
        @(negedge clk); dec_b = 2'b00;
        watch_quiet(1'b1, 30, act);
        n_checks++; if (act !== 1'b0) $display("FAIL sat_low_quiet got activity=%0d exp 0", act); else n_pass++;
        n_checks++; if (cnt_b[7:0] !== 8'd0) $display("FAIL sat_low_cnt got %0d exp 0", cnt_b[7:0]); else n_pass++;
        @(negedge clk); inc_b = 2'b01;
        repeat (260) @(negedge clk);
        inc_b = 2'b00;
        last = '0;
        ok = 1'b1;
        for (int i = 0; i < 100 && ok; i++) begin
            recv_byte(1'b1, 20, b, ok);
            if (ok) last = {last[63:0], b};
        end
        n_checks++; if (last !== "C0: 255\r\n") $display("FAIL sat_high_last_line got %h exp %h", last, 72'("C0: 255\r\n")); else n_pass++;
        @(negedge clk); inc_b = 2'b01;
        @(negedge clk); inc_b = 2'b00;
        watch_quiet(1'b1, 30, act);
        n_checks++; if (act !== 1'b0) $display("FAIL sat_high_quiet got activity=%0d exp 0", act); else n_pass++;
        n_checks++; if (cnt_b[7:0] !== 8'd255) $display("FAIL sat_high_cnt got %0d exp 255", cnt_b[7:0]); else n_pass++;
    endtask

    task automatic test_round_robin();
        logic [71:0] line;
        bit ok;
        do_reset(1'b0);
        @(negedge clk); inc_a = 4'b0100;
        @(negedge clk); inc_a = 4'b0000;
        recv_line(1'b0, line, ok);
        n_checks++; if (!ok || line !== "C2: 001\r\n") $display("FAIL rr_ch2_line got %h ok=%0d exp %h", line, ok, 72'("C2: 001\r\n")); else n_pass++;
        repeat (2) @(negedge clk);
        inc_a = 4'b1010;
        @(negedge clk); inc_a = 4'b0000;
        recv_line(1'b0, line, ok);
        n_checks++; if (!ok || line !== "C3: 001\r\n") $display("FAIL rr_first_ch3 got %h ok=%0d exp %h", line, ok, 72'("C3: 001\r\n")); else n_pass++;
        recv_line(1'b0, line, ok);
        n_checks++; if (!ok || line !== "C1: 001\r\n") $display("FAIL rr_second_ch1 got %h ok=%0d exp %h", line, ok, 72'("C1: 001\r\n")); else n_pass++;
    endtask

    task automatic test_inc_dec_same();
        bit act;
        repeat (3) @(negedge clk);
        inc_a = 4'b0001; dec_a = 4'b0001;
        @(negedge clk); inc_a = 4'b0000; dec_a = 4'b0000;
        watch_quiet(1'b0, 20, act);
        n_checks++; if (act !== 1'b0) $display("FAIL both_quiet got activity=%0d exp 0", act); else n_pass++;
        n_checks++; if (cnt_a[7:0] !== 8'd0) $display("FAIL both_cnt got %0d exp 0", cnt_a[7:0]); else n_pass++;
    endtask

    task automatic test_rst_mid_message();
        logic [71:0] line;
        logic [31:0] hdr;
        logic [7:0] b;
        bit ok, seen, act;
        @(negedge clk); inc_a = 4'b0001;
        @(negedge clk); inc_a = 4'b0000;
        hdr = '0;
        ok = 1'b1;
        for (int i = 0; i < 4 && ok; i++) begin
            recv_byte(1'b0, 200, b, ok);
            hdr = {hdr[23:0], b};
        end
        n_checks++; if (!ok || hdr !== "C0: ") $display("FAIL rstmid_header got %h exp %h", hdr, 32'("C0: ")); else n_pass++;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (!if_a.empty) seen = 1'b1;
        end
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        n_checks++; if (!seen || if_a.empty !== 1'b1) $display("FAIL rstmid_empty got %b seen=%0d exp 1", if_a.empty, seen); else n_pass++;
        n_checks++; if (cnt_a !== 32'h0 || busy_a !== 1'b0) $display("FAIL rstmid_state got cnt=%h busy=%b exp 0/0", cnt_a, busy_a); else n_pass++;
        watch_quiet(1'b0, 30, act);
        n_checks++; if (act !== 1'b0) $display("FAIL rstmid_no_resume got activity=%0d exp 0", act); else n_pass++;
        @(negedge clk); inc_a = 4'b0001;
        @(negedge clk); inc_a = 4'b0000;
        recv_line(1'b0, line, ok);
        n_checks++; if (!ok || line !== "C0: 001\r\n") $display("FAIL rstmid_fresh_line got %h ok=%0d exp %h", line, ok, 72'("C0: 001\r\n")); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_lines();
        test_coalesce();
        test_wrap();
        test_saturate();
        test_round_robin();
        test_inc_dec_same();
        test_rst_mid_message();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
